// File: rtl/rr_mux_2_1_pkg.sv
// Shared definitions for the round-robin 2:1 mux stage.
//   CH0/CH1     : channel indices as they appear on s0 and in the arbiter.
//   out_state_e : occupancy of the single-entry output register.
package mux_defs;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/rr_mux_2_1_if.sv
// Handshake/bus bundle for rr_mux_2_1.
// Valid/ready rule for every channel: a word moves on a rising clk edge
// exactly when valid and ready are both 1 in the cycle before that edge.
// The producer holds the word and valid stable until the transfer happens.
// Ready never depends combinationally on the same channel's ready.
//   slave  : the mux side (consumes i0/i1, produces out/s0/counters).
//   master : the environment side.
//   dbg_state mirrors the output-register FSM for observation.
interface rr_mux_2_1_if #(
  parameter int W     = 1,
  parameter int CNT_W = 8
);
  import mux_defs::*;

  logic [W-1:0]     i0;
  logic             i0_valid;
  logic             i0_ready;
  logic [W-1:0]     i1;
  logic             i1_valid;
  logic             i1_ready;
  logic [W-1:0]     out;
  logic             out_valid;
  logic             out_ready;
  logic             s0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  out_state_e       dbg_state;

  modport slave (
    input  i0, i0_valid, i1, i1_valid, out_ready,
    output i0_ready, i1_ready, out, out_valid, s0, cnt0, cnt1, dbg_state
  );

  modport master (
    output i0, i0_valid, i1, i1_valid, out_ready,
    input  i0_ready, i1_ready, out, out_valid, s0, cnt0, cnt1, dbg_state
  );
endinterface

// File: rtl/rr_mux_2_1_arb.sv
// rr_arb_2: two-requester round-robin arbiter.
//   clk, rst : clock, async active-high reset (prio -> CH0).
//   req0/1   : requests.
//   en       : grants are only issued while en=1.
//   gnt0/1   : one-hot (or zero) grant.
//   gidx     : index of the granted channel (CH0 when no grant).
// The priority pointer only moves when a grant is issued, so a lone
// requester keeps its turn until the other channel actually competes.
module rr_arb_2
  import mux_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1,
  output logic gidx
);
  logic prio_q, prio_d;

  always_comb begin
    gnt0   = en && req0 && (!req1 || (prio_q == CH0));
    gnt1   = en && req1 && (!req0 || (prio_q == CH1));
    gidx   = gnt1 ? CH1 : CH0;
    prio_d = prio_q;
    // Winner yields priority to the other channel.
    if (gnt0 || gnt1) prio_d = ~gidx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= CH0;
    else     prio_q <= prio_d;
  end
endmodule

// File: rtl/rr_mux_2_1.sv
// rr_mux_2_1: registered, round-robin arbitrated 2:1 mux stage.
//   clk, rst : clock, async active-high reset.
//   bus      : rr_mux_2_1_if.slave - i0/i1 channels in, out channel out,
//              registered select s0, saturating grant counters cnt0/cnt1,
//              dbg_state (output register occupancy).
// A single output register accepts a new word whenever it is empty or
// being drained in the same cycle, giving one word per cycle throughput.
module rr_mux_2_1
  import mux_defs::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  rr_mux_2_1_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  out_state_e       state_q, state_d;
  logic [W-1:0]     out_q, out_d;
  logic             s0_q, s0_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic load, en, gnt0, gnt1, gidx;

  assign load = (state_q == OUT_EMPTY) || bus.out_ready;
  // rst gates the enable so no handshake can complete while reset is held.
  assign en   = load && !rst;

  rr_arb_2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (bus.i0_valid),
    .req1 (bus.i1_valid),
    .en   (en),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .gidx (gidx)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    s0_d    = s0_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (gnt0 || gnt1) begin
      // Load (possibly replacing a word drained this same edge).
      state_d = OUT_FULL;
      out_d   = gidx ? bus.i1 : bus.i0;
      s0_d    = gidx;
      if (gnt0 && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_ONE;
      if (gnt1 && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_ONE;
    end else if ((state_q == OUT_FULL) && bus.out_ready) begin
      // Drain without refill: data and select keep their last values.
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      out_q   <= '0;
      s0_q    <= CH0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      s0_q    <= s0_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.i0_ready  = gnt0;
  assign bus.i1_ready  = gnt1;
  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.s0        = s0_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/rr_mux_2_1.md
Name: rr_mux_2_1

Overview:
- Registered, arbitrated 2:1 multiplexer stage. It feeds the downstream 2:1 select datapath.
- Two upstream producers present data with valid/ready handshakes.
- The block picks one per cycle with round-robin fairness and holds the winner in an output register.
- It exposes the registered select bit (s0) so the downstream gate-level mux and its display bench can observe which input was routed.

Parameters:
- W, 1, data width of i0/i1/out.
- CNT_W, 8, width of the per-channel saturating grant counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i0  input  W  channel 0 data.
- i0_valid  input  1  channel 0 data present.
- i0_ready  output  1  channel 0 accepted this cycle when i0_valid and i0_ready are both 1.
- i1  input  W  channel 1 data.
- i1_valid  input  1  channel 1 data present.
- i1_ready  output  1  channel 1 accepted this cycle.
- out  output  W  registered selected data.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  downstream takes out when out_valid and out_ready are both 1.
- s0  output  1  registered select: 0 means out came from i0, 1 means from i1.
- cnt0  output  CNT_W  number of channel 0 grants, saturating.
- cnt1  output  CNT_W  number of channel 1 grants, saturating.

Behaviour:
- Reset (async, immediate, regardless of clk):
  - out=0, out_valid=0, s0=0, cnt0=0, cnt1=0.
  - Priority pointer prio=0, meaning channel 0 is preferred next.
- Output register has a single entry, with two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load = !out_valid || out_ready, combinational. The register can accept a new word this cycle.
- Grant, combinational, evaluated only when load=1:
  - Only i0_valid: grant channel 0.
  - Only i1_valid: grant channel 1.
  - Both valid: grant channel prio.
  - Neither valid: no grant.
- Ready outputs:
  - i0_ready = load && grant==0 && i0_valid.
  - i1_ready is the analogous term for channel 1.
  - At most one ready is high per cycle. Ready never depends on the same channel's own ready (no loop).
- On a grant at the clock edge:
  - out <= granted data; s0 <= granted index; out_valid <= 1.
  - prio <= ~granted index.
  - Granted counter increments unless it is at all-ones, where it holds (saturates).
- Drain without refill (out_valid && out_ready, no grant): out_valid <= 0. out and s0 hold their last values.
- Simultaneous drain and grant: the new word replaces the old one in the same edge and out_valid stays 1. Throughput is 1 word/cycle.
- FULL with out_ready=0:
  - out, s0, out_valid are stable.
  - Both readies are 0.
  - prio and the counters do not change.
- Latency: an accepted input appears on out the cycle after acceptance.
- prio changes only on a grant. A lone requester does not lose its turn to an absent one, but after being granted it yields priority to the other channel.
- Reset asserted mid-transfer drops any held word: out_valid goes to 0 immediately. No handshake completes during reset; both readies are 0 while rst=1.

Decomposition:
- Shared package/include (mux_defs): localparams CH0=1'b0, CH1=1'b1.
- One natural sub-module, rr_arb_2: prio register plus grant logic. Inputs req0, req1, en. Outputs gnt0, gnt1, gidx.
- The top level holds the output register and the counters.

Test Plan:
- Reset: hold rst=1 with random inputs -> out_valid=0, s0=0, cnt0=cnt1=0, i0_ready=i1_ready=0. Deassert with out_ready=1 and only i0_valid=1, i0=1 -> next cycle out=1, s0=0, cnt0=1.
- Alternation: i0=0, i1=1, both valid, out_ready=1 for 6 cycles -> s0 sequence 0,1,0,1,0,1; cnt0=cnt1=3.
- Backpressure: both valid, out_ready=0 after first load -> out, s0 frozen; readies 0; counters unchanged. Release out_ready -> next grant goes to the other channel.
- Drain without refill: one word loaded, then valids=0, out_ready=1 -> out_valid=0 next cycle; s0 holds.
- Saturation: CNT_W=2, i1 alone valid for 5 accepts -> cnt1=3 and holds; cnt0=0.
- Async reset mid-stream: pulse rst between clock edges while out_valid=1 -> out_valid drops to 0 before the next edge; prio=0, so the first grant after release with both valid goes to channel 0.
